// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants, state encoding and counter helper for the branch predictor
package pipeline_pkg;

    localparam int PC_W = 32;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // One step of a saturating up/down counter bounded by [0, max]
    function automatic logic [31:0] sat_step(
        input logic [31:0] value,
        input logic [31:0] max,
        input logic        up
    );
        if (up) return (value == max) ? value : value + 32'd1;
        return (value == 32'd0) ? value : value - 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_bpred_sat_ctr.sv
// bpred_sat_ctr: saturating statistics counter with synchronous clear
module bpred_sat_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear beats a same-cycle increment; counting stops at all ones
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_bpred.sv
// pipeline_bpred: direct-mapped BTB with saturating direction counters and hit/mispredict statistics
module pipeline_bpred
    import pipeline_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic              ready,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              upd_jump,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispred,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispred,
    input  logic              stat_clear
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = ~(CTR_MAX >> 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] sweep_ptr;

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [CTR_W-1:0] tbl_ctr    [ENTRIES];
    logic [PC_W-1:0]  tbl_target [ENTRIES];

    logic             run;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, eff_taken, count_en, write_en;
    logic [CTR_W-1:0] ctr_step;

    assign run       = (state == ST_RUN);
    assign ready     = run;
    assign lk_idx    = if_pc[IDX_W+1:2];
    assign lk_tag    = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx    = upd_pc[IDX_W+1:2];
    assign up_tag    = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_hit    = run && tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
    assign up_hit    = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
    assign eff_taken = upd_taken | upd_jump;
    assign count_en  = run & upd_valid;
    assign write_en  = count_en & ~reset & (up_hit | eff_taken);
    assign ctr_step  = CTR_W'(sat_step(32'(tbl_ctr[up_idx]), 32'(CTR_MAX), upd_taken));

    // Lookup reads the registered table only, so a same-cycle update is seen next cycle
    always_comb begin
        pred_hit    = lk_hit;
        pred_taken  = lk_hit & tbl_ctr[lk_idx][CTR_W-1];
        pred_target = lk_hit ? tbl_target[lk_idx] : if_pc + 32'd4;
    end

    // INIT sweeps one entry per cycle and hands over to RUN after the last index
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else if (state == ST_INIT) begin
            sweep_ptr <= sweep_ptr + 1'b1;
            if (sweep_ptr == IDX_W'(ENTRIES - 1)) state <= ST_RUN;
        end
    end

    // Sweep invalidation, then training on hits and allocation on taken misses
    always_ff @(posedge clk) begin
        if (!reset && !run) begin
            tbl_valid[sweep_ptr] <= 1'b0;
        end else if (write_en) begin
            tbl_valid[up_idx] <= 1'b1;
            tbl_tag[up_idx]   <= up_tag;
            tbl_ctr[up_idx]   <= upd_jump ? CTR_MAX : up_hit ? ctr_step : CTR_WEAK;
            if (eff_taken) tbl_target[up_idx] <= upd_target;
        end
    end

    bpred_sat_ctr #(.W(STAT_W)) u_lookups (
        .clk   (clk),
        .reset (reset),
        .clear (stat_clear),
        .inc   (count_en),
        .count (stat_lookups)
    );

    bpred_sat_ctr #(.W(STAT_W)) u_mispred (
        .clk   (clk),
        .reset (reset),
        .clear (stat_clear),
        .inc   (count_en & upd_mispred),
        .count (stat_mispred)
    );

endmodule

// File: tb/tb_pipeline_bpred.sv
// tb_pipeline_bpred: directed and randomized checks of pipeline_bpred against a behavioural BTB model
module tb_pipeline_bpred;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc = 32'h0;
    logic        pred_hit, pred_taken, ready;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic        upd_jump = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_mispred = 1'b0;
    logic [15:0] stat_lookups, stat_mispred;
    logic        stat_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    pipeline_bpred #(.ENTRIES(16), .TAG_W(8), .CTR_W(2), .STAT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_pc        (if_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .ready        (ready),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_jump     (upd_jump),
        .upd_target   (upd_target),
        .upd_mispred  (upd_mispred),
        .stat_lookups (stat_lookups),
        .stat_mispred (stat_mispred),
        .stat_clear   (stat_clear)
    );

    always #5 clk = ~clk;

    // Behavioural model: 16 slots, counter kept as an integer in 0..3
    bit          m_valid [16];
    int          m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    bit          m_run = 1'b0;
    int          m_lookups = 0;
    int          m_mispred = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    function automatic logic [31:0] rand_pc();
        return 32'h00400000 | (($urandom % 4) << 6) | (($urandom % 16) << 2);
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit taken, input bit jump,
                                         input logic [31:0] target, input bit mp);
        int i;
        int t;
        if (!m_run) return;
        i = idx_of(pc);
        t = tag_of(pc);
        if (m_lookups < 65535) m_lookups++;
        if (mp && m_mispred < 65535) m_mispred++;
        if (m_valid[i] && m_tag[i] == t) begin
            if (jump) m_ctr[i] = 3;
            else if (taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            if (taken || jump) m_tgt[i] = target;
        end else if (taken || jump) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_tgt[i]   = target;
            m_ctr[i]   = jump ? 3 : 2;
        end
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output bit hit, output bit tk,
                                          output logic [31:0] tgt);
        int i;
        i   = idx_of(pc);
        hit = m_run && m_valid[i] && m_tag[i] == tag_of(pc);
        tk  = hit && m_ctr[i] >= 2;
        tgt = hit ? m_tgt[i] : pc + 32'd4;
    endfunction

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        m_run = 1'b0;
        m_lookups = 0;
        m_mispred = 0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        #1 reset = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input bit taken, input bit jump,
                             input logic [31:0] target, input bit mp);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_taken   = taken;
        upd_jump    = jump;
        upd_target  = target;
        upd_mispred = mp;
        @(posedge clk);
        model_update(pc, taken, jump, target, mp);
        #1;
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
        upd_jump    = 1'b0;
        upd_mispred = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        if_pc       = 32'h00400010;
        upd_valid   = 1'b1;
        upd_pc      = 32'h00400030;
        upd_taken   = 1'b1;
        upd_target  = 32'h00400300;
        upd_mispred = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({ready, pred_hit, pred_taken, pred_target} !== {3'b000, 32'h00400014}) begin
                errors++;
                $display("FAIL reset_sweep cycle %0d: ready=%b hit=%b taken=%b target=%h, expected 0 0 0 00400014",
                         i, ready, pred_hit, pred_taken, pred_target);
            end
            @(posedge clk);
        end
        #1;
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
        m_run       = 1'b1;
        if_pc       = 32'h00400030;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b, expected 1", ready);
        end
        checks++;
        if ({stat_lookups, stat_mispred} !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: lookups=%0d mispred=%0d, expected 0 0", stat_lookups, stat_mispred);
        end
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL init_update_ignored: hit=%b, expected 0", pred_hit);
        end
    endtask

    task automatic test_allocation();
        do_update(32'h00400010, 1'b1, 1'b0, 32'h00400100, 1'b0);
        if_pc = 32'h00400010;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h00400100}) begin
            errors++;
            $display("FAIL allocation: hit=%b taken=%b target=%h, expected 1 1 00400100",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_saturation();
        do_update(32'h00400010, 1'b1, 1'b0, 32'h00400100, 1'b0);
        do_update(32'h00400010, 1'b1, 1'b0, 32'h00400100, 1'b0);
        do_update(32'h00400010, 1'b0, 1'b0, 32'h00400DEC, 1'b0);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h00400100}) begin
            errors++;
            $display("FAIL sat_one_not_taken: hit=%b taken=%b target=%h, expected 1 1 00400100",
                     pred_hit, pred_taken, pred_target);
        end
        do_update(32'h00400010, 1'b0, 1'b0, 32'h00400DEC, 1'b0);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b10, 32'h00400100}) begin
            errors++;
            $display("FAIL sat_two_not_taken: hit=%b taken=%b target=%h, expected 1 0 00400100",
                     pred_hit, pred_taken, pred_target);
        end
        repeat (3) do_update(32'h00400010, 1'b0, 1'b0, 32'h00400DEC, 1'b0);
        do_update(32'h00400010, 1'b1, 1'b0, 32'h00400100, 1'b0);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b10, 32'h00400100}) begin
            errors++;
            $display("FAIL sat_floor: hit=%b taken=%b target=%h, expected 1 0 00400100",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h00400410;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h00400414}) begin
            errors++;
            $display("FAIL alias_miss: hit=%b taken=%b target=%h, expected 0 0 00400414",
                     pred_hit, pred_taken, pred_target);
        end
        do_update(32'h00400410, 1'b1, 1'b0, 32'h00400200, 1'b0);
        if_pc = 32'h00400010;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h00400014}) begin
            errors++;
            $display("FAIL alias_evicted: hit=%b taken=%b target=%h, expected 0 0 00400014",
                     pred_hit, pred_taken, pred_target);
        end
        if_pc = 32'h00400410;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h00400200}) begin
            errors++;
            $display("FAIL alias_replaced: hit=%b taken=%b target=%h, expected 1 1 00400200",
                     pred_hit, pred_taken, pred_target);
        end
        do_update(32'h00400030, 1'b0, 1'b0, 32'h00400900, 1'b0);
        if_pc = 32'h00400030;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h00400034}) begin
            errors++;
            $display("FAIL miss_not_taken: hit=%b taken=%b target=%h, expected 0 0 00400034",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_jump_same_cycle();
        if_pc       = 32'h00400020;
        upd_valid   = 1'b1;
        upd_pc      = 32'h00400020;
        upd_taken   = 1'b0;
        upd_jump    = 1'b1;
        upd_target  = 32'h00400800;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h00400024}) begin
            errors++;
            $display("FAIL jump_same_cycle: hit=%b taken=%b target=%h, expected 0 0 00400024",
                     pred_hit, pred_taken, pred_target);
        end
        @(posedge clk);
        model_update(32'h00400020, 1'b0, 1'b1, 32'h00400800, 1'b0);
        #1;
        upd_valid = 1'b0;
        upd_jump  = 1'b0;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h00400800}) begin
            errors++;
            $display("FAIL jump_next_cycle: hit=%b taken=%b target=%h, expected 1 1 00400800",
                     pred_hit, pred_taken, pred_target);
        end
        do_update(32'h00400020, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h00400800}) begin
            errors++;
            $display("FAIL jump_strong: hit=%b taken=%b target=%h, expected 1 1 00400800",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_stats();
        stat_clear = 1'b1;
        @(posedge clk);
        m_lookups = 0;
        m_mispred = 0;
        #1 stat_clear = 1'b0;
        for (int i = 0; i < 5; i++)
            do_update(32'h00400080 + 32'(i * 4), 1'(i % 2), 1'b0, 32'h00400C00, (i == 1 || i == 3));
        checks++;
        if ({stat_lookups, stat_mispred} !== {16'd5, 16'd2}) begin
            errors++;
            $display("FAIL stats_count: lookups=%0d mispred=%0d, expected 5 2", stat_lookups, stat_mispred);
        end
        upd_mispred = 1'b1;
        @(posedge clk);
        #1 upd_mispred = 1'b0;
        checks++;
        if (stat_mispred !== 16'd2) begin
            errors++;
            $display("FAIL stats_mispred_no_valid: mispred=%0d, expected 2", stat_mispred);
        end
        stat_clear = 1'b1;
        do_update(32'h00400040, 1'b1, 1'b0, 32'h00400A00, 1'b1);
        m_lookups  = 0;
        m_mispred  = 0;
        stat_clear = 1'b0;
        if_pc      = 32'h00400040;
        #1;
        checks++;
        if ({stat_lookups, stat_mispred} !== 32'h0) begin
            errors++;
            $display("FAIL stats_clear_priority: lookups=%0d mispred=%0d, expected 0 0", stat_lookups, stat_mispred);
        end
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h00400A00}) begin
            errors++;
            $display("FAIL clear_keeps_update: hit=%b target=%h, expected 1 00400a00", pred_hit, pred_target);
        end
    endtask

    task automatic test_random();
        bit          e_hit, e_tk;
        logic [31:0] e_tgt;
        for (int n = 0; n < 400; n++) begin
            if_pc       = rand_pc();
            upd_valid   = ($urandom % 4) != 0;
            upd_pc      = ($urandom % 2) ? if_pc : rand_pc();
            upd_taken   = 1'($urandom % 2);
            upd_jump    = ($urandom % 6) == 0;
            upd_target  = $urandom & 32'hFFFF_FFFC;
            upd_mispred = 1'($urandom % 2);
            stat_clear  = ($urandom % 40) == 0;
            #1;
            model_predict(if_pc, e_hit, e_tk, e_tgt);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== {e_hit, e_tk, e_tgt}) begin
                errors++;
                $display("FAIL random_pred %0d pc=%h: hit=%b taken=%b target=%h, expected %b %b %h",
                         n, if_pc, pred_hit, pred_taken, pred_target, e_hit, e_tk, e_tgt);
            end
            @(posedge clk);
            if (upd_valid) model_update(upd_pc, upd_taken, upd_jump, upd_target, upd_mispred);
            if (stat_clear) begin
                m_lookups = 0;
                m_mispred = 0;
            end
            #1;
            checks++;
            if ({stat_lookups, stat_mispred} !== {16'(m_lookups), 16'(m_mispred)}) begin
                errors++;
                $display("FAIL random_stats %0d: lookups=%0d mispred=%0d, expected %0d %0d",
                         n, stat_lookups, stat_mispred, m_lookups, m_mispred);
            end
        end
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
        upd_jump    = 1'b0;
        upd_mispred = 1'b0;
        stat_clear  = 1'b0;
    endtask

    task automatic test_midrun_reset();
        apply_reset(2);
        repeat (5) @(posedge clk);
        #1;
        apply_reset(1);
        for (int i = 0; i < 16; i++) begin
            if_pc = rand_pc();
            #1;
            checks++;
            if ({ready, pred_hit} !== 2'b00) begin
                errors++;
                $display("FAIL midrun_sweep cycle %0d: ready=%b hit=%b, expected 0 0", i, ready, pred_hit);
            end
            @(posedge clk);
        end
        #1;
        m_run = 1'b1;
        checks++;
        if ({ready, stat_lookups, stat_mispred} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL midrun_ready: ready=%b lookups=%0d mispred=%0d, expected 1 0 0",
                     ready, stat_lookups, stat_mispred);
        end
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) begin
                if_pc = 32'h00400000 | 32'(t << 6) | 32'(i << 2);
                #1;
                checks++;
                if (pred_hit !== 1'b0) begin
                    errors++;
                    $display("FAIL midrun_all_miss pc=%h: hit=%b, expected 0", if_pc, pred_hit);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_allocation();
        test_saturation();
        test_alias();
        test_jump_same_cycle();
        test_stats();
        test_random();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_bpred.md
Name: pipeline_bpred

Overview:
Parametrised branch target buffer with saturating-counter direction prediction for the IF stage of the 5-stage MIPS pipeline.
- Lookup is combinational on the fetch PC, so IF can select a predicted next PC in the same cycle.
- The table is updated by the stage that resolves branches and jumps (ID today, EX later).
- Replaces the current static not-taken fetch, and adds misprediction/hit statistics for the UART debug dump.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES).
TAG_W, 8, tag width, taken from pc[IDX_W+TAG_W+1 : IDX_W+2].
CTR_W, 2, saturating direction-counter width, ≥1.
STAT_W, 16, width of the statistics counters.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
if_pc  in  32  current fetch PC (word aligned).
pred_hit  out  1  valid entry with matching tag for if_pc.
pred_taken  out  1  pred_hit & counter MSB set.
pred_target  out  32  stored target on hit, else if_pc+4.
ready  out  1  init sweep complete.
upd_valid  in  1  resolved control-flow instruction this cycle.
upd_pc  in  32  PC of the resolved instruction.
upd_taken  in  1  actual direction.
upd_jump  in  1  unconditional (j/jal/jr); implies taken.
upd_target  in  32  actual target address.
upd_mispred  in  1  pipeline flushed due to a wrong prediction.
stat_lookups  out  STAT_W  resolved updates counted.
stat_mispred  out  STAT_W  mispredictions counted.
stat_clear  in  1  clear statistics counters.

Behaviour:
- **Index and tag:** idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Bits [1:0] are ignored.
- **Entry contents:** valid, tag, CTR_W counter, 32-bit target.
- **States:** INIT and RUN.
  - reset=1 at any clock edge, including mid-sweep or mid-run, forces INIT and sets sweep pointer=0.
  - INIT clears one entry's valid bit per cycle, from idx 0 to ENTRIES-1.
  - The cycle after the last clear, the state becomes RUN and ready goes to 1.
  - ready=0 for exactly ENTRIES cycles after reset deasserts.
- **Reset values:** ready=0; stat counters=0; sweep pointer=0.
  - Predictions are forced to pred_hit=0, pred_taken=0, pred_target=if_pc+4 while in INIT.
  - Updates during INIT are ignored and not counted.
- **Lookup:** purely combinational from the registered table; 0-cycle latency.
- **Update rules** (RUN, upd_valid=1), written at the clock edge; eff_taken = upd_taken | upd_jump:
  - **Hit** (valid & tag match):
    - upd_jump: counter = all ones.
    - Otherwise: counter +1 if taken, -1 if not taken, saturating at all ones / 0.
    - If eff_taken, target = upd_target. Not-taken leaves target unchanged.
  - **Miss, eff_taken:** allocate (overwrite the direct-mapped slot).
    - valid=1, tag set, target=upd_target.
    - counter = all ones if upd_jump, else 1 followed by zeros (weakly taken, 2'b10 for CTR_W=2).
  - **Miss, not taken:** no change.
- **Simultaneous lookup and update to the same idx:** the lookup returns pre-update contents; the new contents are visible the next cycle (no bypass).
- **Statistics:**
  - stat_lookups increments on each counted update.
  - stat_mispred increments when upd_valid & upd_mispred.
  - Both saturate at all ones.
  - stat_clear zeroes both; clear has priority over same-cycle increments.
- **Unsupported input:** upd_mispred without upd_valid is ignored.

Decomposition:
- Shared package (pipeline_pkg): constants PC_W=32 and the INIT/RUN state encoding; localparams IDX_W, ENTRY_W.
- Helper function: saturating counter update.
- One natural sub-module: bpred_sat_ctr (STAT_W saturating counter with clear and increment), instantiated twice for the statistics.
- The table lives in the main module as a register array.

Test Plan (ENTRIES=16, TAG_W=8, CTR_W=2):
- **Reset sweep:** hold reset 3 cycles, release → ready=0 for 16 cycles, then 1; during the sweep, if_pc=0x00400010 gives pred_hit=0, pred_target=0x00400014.
- **Allocation:** upd pc=0x00400010, taken=1, target=0x00400100 → next cycle, if_pc=0x00400010 gives hit=1, taken=1, target=0x00400100 (counter=2'b10).
- **Saturation and hysteresis:** two further taken updates → counter=11. Two not-taken → counter=01, pred_taken=0, target still 0x00400100. Three more not-taken → counter stays 00.
- **Alias/tag mismatch:** after the allocation, if_pc=0x00400410 (same idx 4, tag 0x10) → hit=0, target=0x00400414. A taken update at 0x00400410 replaces the entry; 0x00400010 then misses.
- **Jump plus same-cycle lookup:** upd_jump at pc=0x00400020 (target 0x00400800) with if_pc=0x00400020 in the same cycle → that cycle hit=0; next cycle hit=1, taken=1, counter=11.
- **Statistics and mid-run reset:** 5 updates with 2 mispred → lookups=5, mispred=2. stat_clear together with an update → both 0. Reset mid-run → all entries miss and ready=0 for 16 cycles.
